// File: rtl/sync_filter_pkg.sv
// Shared elaboration limits for the synchronise-and-filter block.
package sync_filter_pkg;

    localparam int SF_MIN_STAGES     = 2;
    localparam int SF_MIN_FILTER_LEN = 1;

    function automatic bit sf_params_ok(input int stages, input int filter_len);
        return (stages >= SF_MIN_STAGES) && (filter_len >= SF_MIN_FILTER_LEN);
    endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: metastability chain, qualified-sample debounce counter, edge pulses.
module sync_filter_channel #(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic sample_en,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [STAGES-1:0] sync_p;
    logic [CNT_W-1:0]  cnt;
    logic              s;

    assign s = sync_p[STAGES-1];

    // sync_p[0] is the only flop that sees the asynchronous d
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= {STAGES{RESET_VAL}};
            q      <= RESET_VAL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (s == q) begin
                cnt <= '0;
            end else if (sample_en) begin
                if (cnt == CNT_LAST) begin
                    q    <= s;
                    cnt  <= '0;
                    rise <= s;
                    fall <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchroniser with per-channel debounce and rise/fall pulse outputs.
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             sample_en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (!sf_params_ok(STAGES, FILTER_LEN)) begin : g_bad_params
        $error("sync_filter: STAGES must be >= %0d and FILTER_LEN >= %0d",
               SF_MIN_STAGES, SF_MIN_FILTER_LEN);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_channel #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .d          (d[i]),
            .sample_en  (sample_en),
            .q          (q[i]),
            .rise       (rise[i]),
            .fall       (fall[i])
        );
    end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent single-bit channels.
REQ-002 Parameter STAGES, default 2: synchroniser flop depth per channel.
REQ-003 Parameter FILTER_LEN, default 4: consecutive qualified samples required to accept a new level.
REQ-004 Parameter RESET_VAL [WIDTH-1:0], default all-zero: reset level of the chain and of q.
REQ-005 Port clk, input, 1: sole clock; one clock; reset is synchronous and active-high.
REQ-006 Port rst, input, 1: synchronous active-high reset, sampled on the clk rising edge.
REQ-007 Port d, input, WIDTH: asynchronous inputs, one bit per channel.
REQ-008 Port sample_en, input, 1: qualifies filter-counter advance; common to all channels.
REQ-009 Port q, output, WIDTH: synchronised and filtered level per channel.
REQ-010 Port rise, output, WIDTH: one-cycle pulse when the channel's q goes 0->1.
REQ-011 Port fall, output, WIDTH: one-cycle pulse when the channel's q goes 1->0.

Function
REQ-012 Each channel SHALL pass d through a STAGES-deep flop chain; s denotes the last stage.
REQ-013 The chain SHALL shift every clk edge, independent of sample_en.
REQ-014 Each channel SHALL hold a counter cnt of width $clog2(FILTER_LEN+1).
REQ-015 If s==q: cnt<=0, q unchanged, regardless of sample_en.
REQ-016 If s!=q and sample_en==0: cnt and q hold.
REQ-017 If s!=q, sample_en==1, cnt<FILTER_LEN-1: cnt<=cnt+1.
REQ-018 If s!=q, sample_en==1, cnt==FILTER_LEN-1: q<=s, cnt<=0.
REQ-019 rise/fall SHALL be registered and assert in the same cycle q takes its new value, for exactly one cycle.
REQ-020 rise and fall for one channel SHALL never assert together.
REQ-021 sample_en held 1, d stable from before edge k: q SHALL change on edge k+STAGES+FILTER_LEN-1 (latency STAGES+FILTER_LEN edges).
REQ-022 A mismatch at s lasting fewer than FILTER_LEN qualified samples SHALL NOT change q.
REQ-023 An s==q cycle, even with sample_en==0, SHALL restart the count from zero.
REQ-024 FILTER_LEN==1 SHALL give pure synchronisation with one register of latency after s.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL be handled in parallel.
REQ-026 STAGES<2 or FILTER_LEN<1 SHALL cause an elaboration error.

Reset
REQ-027 With rst==1 at an edge: all chain flops and q <= RESET_VAL, cnt <= 0, rise and fall <= 0.
REQ-028 Reset SHALL override all function rules; reset mid-count SHALL discard the partial count with no pulse.
REQ-029 The first cycle after reset release SHALL produce no rise/fall unless REQ-018 fires.

Structure
REQ-030 No shared-package typedefs needed; counter width SHALL be a local constant derived from FILTER_LEN.
REQ-031 One sub-module, sync_filter_channel (one chain, counter, q, rise, fall), SHALL be instantiated WIDTH times via generate.
REQ-032 The chain's first flop is the only async capture point; the SDC SHALL false-path its d input.

Verification
REQ-033 WIDTH=1, STAGES=2, FILTER_LEN=4, sample_en=1: d 0->1 held -> q=1 and rise=1 exactly 6 edges later, one cycle only.
REQ-034 Same config: d=1 pulse of 3 cycles -> q stays 0, rise never asserts, cnt returns to 0.
REQ-035 Same config: sample_en=1 every 2nd cycle, d 0->1 held -> q changes after 2 + 4 qualified samples.
REQ-036 Reset mid-count (cnt=2): rst=1 one cycle -> q=RESET_VAL, cnt=0, no pulse; afterwards full 6-edge latency.
REQ-037 WIDTH=4, RESET_VAL=4'b1010: d=4'b0101 at one edge -> q=4'b0101; rise=4'b0101 and fall=4'b1010 in the same cycle.
REQ-038 FILTER_LEN=1, STAGES=3: d toggles each 4 cycles -> q follows with 4-edge latency; every edge gives exactly one rise/fall pulse.
